// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory op at a time, word-aligned dmem port with byte enables,
// replicated store data and sign/zero-extended load results.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_mbe,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        rsp_valid,
    output logic [31:0] load_data,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        op_load;
    logic [2:0]  op_f3;
    logic [1:0]  op_a;
    logic        is_byte, is_half, req_mis;
    logic [3:0]  mbe_nxt;
    logic [31:0] wdata_nxt, fmt_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // funct3[1:0] selects the size; 011/110/111 fall through to word
    assign is_byte   = (funct3[1:0] == 2'b00);
    assign is_half   = (funct3[1:0] == 2'b01);
    assign req_mis   = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_mis ? RESP : ACCESS;
            ACCESS:  if (dmem_resp) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mbe_nxt   = 4'b1111;
        wdata_nxt = store_data;
        if (is_byte) begin
            mbe_nxt   = 4'b0001 << addr[1:0];
            wdata_nxt = {4{store_data[7:0]}};
        end else if (is_half) begin
            mbe_nxt   = 4'b0011 << addr[1:0];
            wdata_nxt = {2{store_data[15:0]}};
        end
    end

    assign rd_byte = dmem_rdata[{op_a, 3'b000} +: 8];
    assign rd_half = op_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (op_f3)
            3'b000:  fmt_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  fmt_data = {24'b0, rd_byte};
            3'b001:  fmt_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  fmt_data = {16'b0, rd_half};
            default: fmt_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_load      <= 1'b0;
            op_f3        <= 3'b0;
            op_a         <= 2'b0;
            dmem_address <= 32'b0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_mbe     <= 4'b0;
            dmem_wdata   <= 32'b0;
            rsp_valid    <= 1'b0;
            load_data    <= 32'b0;
            misaligned   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op_load <= req_load;
                    op_f3   <= funct3;
                    op_a    <= addr[1:0];
                    if (req_mis) begin
                        // skip the memory entirely and report straight away
                        rsp_valid  <= 1'b1;
                        misaligned <= 1'b1;
                    end else begin
                        misaligned   <= 1'b0;
                        dmem_address <= {addr[31:2], 2'b00};
                        dmem_read    <= req_load;
                        dmem_write   <= !req_load;
                        dmem_mbe     <= req_load ? 4'b0 : mbe_nxt;
                        if (!req_load) dmem_wdata <= wdata_nxt;
                    end
                end
                ACCESS: if (dmem_resp) begin
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                    rsp_valid  <= 1'b1;
                    if (op_load) load_data <= fmt_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory model, random memory
// latency, directed test-plan cases, reset mid-access, then randomized traffic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_load = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] store_data = 32'b0;
    logic [31:0] dmem_rdata = 32'b0;
    logic        dmem_resp = 1'b0;
    logic        req_ready, dmem_read, dmem_write, rsp_valid, misaligned;
    logic [31:0] dmem_address, dmem_wdata, load_data;
    logic [3:0]  dmem_mbe;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .funct3(funct3), .addr(addr), .store_data(store_data),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .rsp_valid(rsp_valid), .load_data(load_data),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        bit          rd;
        logic [3:0]  mbe;
        logic [31:0] wdata;
        int          dly;
    } acc_t;

    typedef struct {
        bit          mis;
        logic [31:0] data;
        int          lat;
    } rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    int          acc_cyc_q[$];
    bit [7:0]    ref_b[int];
    bit [31:0]   dmem_w[int];
    logic [31:0] last_load = 32'b0;
    int          cyc = 0, passed = 0, total = 0, wait_cnt = 0;
    bit          manual = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_cleared(string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_dmem_read"}, 32'(dmem_read), 32'd0);
        chk({tag, "_dmem_write"}, 32'(dmem_write), 32'd0);
        chk({tag, "_dmem_mbe"}, 32'(dmem_mbe), 32'd0);
        chk({tag, "_dmem_address"}, dmem_address, 32'd0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
        chk({tag, "_load_data"}, load_data, 32'd0);
    endtask

    task automatic preload(int a, bit [31:0] w);
        dmem_w[a >> 2] = w;
        for (int i = 0; i < 4; i++) ref_b[a + i] = w[8*i +: 8];
    endtask

    // Reference: build expectations from byte-addressed memory, then drive the request
    task automatic do_op(bit ld, bit [2:0] f3, logic [31:0] a, logic [31:0] sd, int dly);
        int size, n;
        bit mis;
        logic [31:0] v;
        acc_t e;
        rsp_t r;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        mis   = (int'(a[1:0]) % size) != 0;
        r.mis = mis;
        r.lat = mis ? 0 : 1 + dly;
        if (!mis) begin
            e.waddr = a & ~32'h3;
            e.rd    = ld;
            e.dly   = dly;
            e.mbe   = 4'b0;
            e.wdata = 32'b0;
            if (ld) begin
                v = 32'b0;
                for (int i = 0; i < size; i++) v |= 32'(ref_b[int'(a) + i]) << (8 * i);
                if (size < 4 && !f3[2] && v[8*size-1]) v = v - (32'd1 << (8 * size));
                last_load = v;
            end else begin
                for (int i = 0; i < size; i++) begin
                    e.mbe[int'(a[1:0]) + i] = 1'b1;
                    ref_b[int'(a) + i] = sd[8*i +: 8];
                end
                for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = sd[8*(j % size) +: 8];
            end
            acc_q.push_back(e);
        end
        r.data = last_load;
        rsp_q.push_back(r);

        @(negedge clk);
        req_valid = 1'b1; req_load = ld; funct3 = f3; addr = a; store_data = sd;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_within_bound", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_load = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
        acc_cyc_q.push_back(cyc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || !req_ready) && n < 200) begin @(negedge clk); n++; end
        chk("drain_responses", 32'(rsp_q.size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: checks the port every ACCESS cycle, answers after the queued delay
    initial begin : responder
        acc_t e;
        forever begin
            @(negedge clk);
            if (!manual) begin
                dmem_resp  = 1'b0;
                dmem_rdata = $urandom;
                if (rst && (dmem_read || dmem_write)) begin
                    if (acc_q.size() == 0) begin
                        chk("strobe_without_request", 32'(dmem_read | dmem_write), 32'd0);
                    end else begin
                        e = acc_q[0];
                        chk("dmem_address", dmem_address, e.waddr);
                        chk("dmem_read", 32'(dmem_read), 32'(e.rd));
                        chk("dmem_write", 32'(dmem_write), 32'(!e.rd));
                        chk("dmem_mbe", 32'(dmem_mbe), 32'(e.mbe));
                        if (!e.rd) chk("dmem_wdata", dmem_wdata, e.wdata);
                        chk("req_ready_in_access", 32'(req_ready), 32'd0);
                        if (wait_cnt >= e.dly) begin
                            dmem_resp = 1'b1;
                            if (e.rd) begin
                                dmem_rdata = dmem_w[int'(e.waddr >> 2)];
                            end else begin
                                for (int j = 0; j < 4; j++)
                                    if (dmem_mbe[j]) dmem_w[int'(e.waddr >> 2)][8*j +: 8] = dmem_wdata[8*j +: 8];
                            end
                            void'(acc_q.pop_front());
                            wait_cnt = 0;
                        end else begin
                            wait_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin : monitor
        rsp_t r;
        int a0;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    r  = rsp_q.pop_front();
                    a0 = (acc_cyc_q.size() != 0) ? acc_cyc_q.pop_front() : -100;
                    chk("misaligned", 32'(misaligned), 32'(r.mis));
                    chk("load_data", load_data, r.data);
                    chk("latency", 32'(cyc - a0), 32'(r.lat));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    initial begin
        preload(32'h100, 32'h80FF1234);
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b1;

        do_op(1'b1, 3'b000, 32'h103, 32'h0, 0);            // lb   -> FFFFFF80
        do_op(1'b1, 3'b100, 32'h103, 32'h0, 0);            // lbu  -> 00000080
        do_op(1'b1, 3'b001, 32'h102, 32'h0, 1);            // lh   -> FFFF80FF
        do_op(1'b1, 3'b101, 32'h102, 32'h0, 0);            // lhu  -> 000080FF
        do_op(1'b1, 3'b001, 32'h100, 32'h0, 2);            // lh   -> 00001234
        do_op(1'b0, 3'b000, 32'h1001, 32'h000000AB, 0);    // sb
        do_op(1'b0, 3'b001, 32'h1002, 32'h0000CDEF, 1);    // sh
        do_op(1'b1, 3'b010, 32'h1002, 32'h0, 0);           // lw misaligned
        do_op(1'b1, 3'b010, 32'h1000, 32'h0, 0);           // lw of the two stores
        do_op(1'b1, 3'b010, 32'h100, 32'h0, 5);            // lw, 5 wait states
        do_op(1'b0, 3'b000, 32'h104, 32'h55, 0);           // held during the wait above
        do_op(1'b1, 3'b100, 32'h104, 32'h0, 0);
        wait_idle();

        // reset in the second ACCESS cycle, then a stray dmem_resp
        manual = 1'b1;
        dmem_resp = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; funct3 = 3'b010; addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_dmem_read", 32'(dmem_read), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_cleared("mid_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("post_reset");
        last_load = 32'b0;
        manual = 1'b0;

        for (int k = 0; k < 80; k++) begin
            bit ld;
            bit [2:0] f3;
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            do_op(ld, f3, 32'h100 + 32'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3));
        end
        wait_idle();
        chk("access_queue_empty", 32'(acc_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
